// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: shares the single data-memory port between the single-cycle
// CPU and one external master (debug/loader). The external side is served in
// bounded bursts of at most MAX_BURST transfers; the CPU is frozen through
// cpu_stall while the port is lent out.
//
// Optional feature macro: DMEM_ARB_IO_PROTECT_EN
//   defined     -> external writes with ext_addr[7]=1 (I/O region) are blocked
//                  and flagged by an ext_err pulse alongside ext_ack.
//   not defined -> ext_err stays 0 and all external writes pass through.
//
// Memory read data is valid one cycle after the address is presented, so the
// external address is already driven in HANDOVER; the word read during EXT is
// therefore the one addressed the cycle before.
module sc_dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_we,
    output logic              ext_gnt,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_HANDOVER,
        ST_EXT,
        ST_DONE,
        ST_RELEASE
    } state_t;

    localparam logic [4:0] MAX_B5 = 5'(MAX_BURST);
    localparam logic [3:0] MAX_B4 = 4'(MAX_BURST);

    state_t     state;
    logic [3:0] burst_cnt;
    logic [4:0] burst_inc;
    logic [3:0] burst_next;
    logic       ext_blocked;

`ifdef DMEM_ARB_IO_PROTECT_EN
    assign ext_blocked = ext_we & ext_addr[7];
`else
    assign ext_blocked = 1'b0;
`endif

    // Burst count after this transfer, saturating at MAX_BURST
    assign burst_inc  = {1'b0, burst_cnt} + 5'd1;
    assign burst_next = (burst_inc >= MAX_B5) ? MAX_B4 : burst_inc[3:0];

    assign cpu_rdata = mem_rdata;

    // Memory port mux; writes only from the owner's write cycle, never in reset
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        case (state)
            ST_CPU: mem_we = cpu_we;
            ST_HANDOVER, ST_DONE: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            ST_EXT: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_we & ~ext_blocked;
            end
            default: mem_we = 1'b0;
        endcase
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Ownership FSM; pulse outputs are loaded on the edge entering their state
    // so that ext_gnt/ext_ack/ext_rdata/ext_err are visible during it
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CPU;
            burst_cnt <= '0;
            cpu_stall <= 1'b0;
            ext_gnt   <= 1'b0;
            ext_ack   <= 1'b0;
            ext_err   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_gnt <= 1'b0;
            ext_ack <= 1'b0;
            ext_err <= 1'b0;
            case (state)
                ST_CPU: begin
                    if (ext_req) begin
                        state     <= ST_HANDOVER;
                        cpu_stall <= 1'b1;
                        ext_gnt   <= 1'b1;
                    end
                end
                ST_HANDOVER: begin
                    state <= ST_EXT;
                end
                ST_EXT: begin
                    state     <= ST_DONE;
                    ext_ack   <= 1'b1;
                    ext_rdata <= mem_rdata;
                    ext_err   <= ext_blocked;
                end
                ST_DONE: begin
                    burst_cnt <= burst_next;
                    if (ext_req && (burst_inc < MAX_B5)) begin
                        state <= ST_EXT;
                    end else begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state     <= ST_CPU;
                    burst_cnt <= '0;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state     <= ST_CPU;
                    burst_cnt <= '0;
                    cpu_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Testbench for sc_dmem_arbiter: directed scenarios followed by randomized
// external transfers mixed with random CPU stores, checked against a shadow
// memory kept by the bench.
module tb_sc_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_we;
    logic        ext_gnt;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        ext_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];

    int errors = 0;
    int checks = 0;

    sc_dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_BURST(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .ext_req  (ext_req),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .ext_we   (ext_we),
        .ext_gnt  (ext_gnt),
        .ext_ack  (ext_ack),
        .ext_rdata(ext_rdata),
        .ext_err  (ext_err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: synchronous read (read-before-write), 256 words
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Random CPU activity; a store counts only if the CPU is not frozen
    task automatic cpu_random();
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 32'($urandom_range(0, 127));
        cpu_wdata = $urandom;
        if (!cpu_stall && cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
    endtask

    initial begin
        int acks, burst, done_before, nbursts, gnts, cpu_free, last_ack, exp_b, cyc, lat, gnt_lat;
        logic        r_we;
        logic [7:0]  r_addr;
        logic [31:0] r_data;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem[8'h10]    = 32'hDEADBEEF;
        shadow[8'h10] = 32'hDEADBEEF;

        reset = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h3C; cpu_wdata = 32'h11111111;
        ext_req = 1'b0; ext_addr = '0; ext_wdata = '0; ext_we = 1'b0;

        // ---- reset state ----
        step();
        step();
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_gnt", 32'(ext_gnt), 0);
        chk("rst_ack", 32'(ext_ack), 0);
        chk("rst_err", 32'(ext_err), 0);
        chk("rst_rdata", ext_rdata, 0);
        reset = 1'b0; cpu_we = 1'b0;
        step();
        chk("rst_no_store", mem[8'h3C], 0);

        // ---- single external read from 0x10 ----
        ext_req = 1'b1; ext_addr = 32'h10; ext_we = 1'b0;
        step();
        chk("rd_c1_gnt", 32'(ext_gnt), 1);
        chk("rd_c1_stall", 32'(cpu_stall), 1);
        chk("rd_c1_addr", mem_addr, 32'h10);
        step();
        chk("rd_c2_gnt", 32'(ext_gnt), 0);
        chk("rd_c2_ack", 32'(ext_ack), 0);
        step();
        chk("rd_c3_ack", 32'(ext_ack), 1);
        chk("rd_c3_rdata", ext_rdata, 32'hDEADBEEF);
        chk("rd_c3_stall", 32'(cpu_stall), 1);
        ext_req = 1'b0;
        step();
        chk("rd_c4_ack", 32'(ext_ack), 0);
        chk("rd_c4_stall", 32'(cpu_stall), 1);
        step();
        chk("rd_c5_stall", 32'(cpu_stall), 0);

        // ---- external write 0x12345678 to 0x20, then CPU load ----
        ext_req = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678; ext_we = 1'b1;
        step();
        chk("wr_hand_we", 32'(mem_we), 0);
        step();
        chk("wr_ext_we", 32'(mem_we), 1);
        step();
        chk("wr_done_we", 32'(mem_we), 0);
        chk("wr_done_ack", 32'(ext_ack), 1);
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        chk("wr_rel_we", 32'(mem_we), 0);
        step();
        shadow[8'h20] = 32'h12345678;
        cpu_addr = 32'h20;
        step();
        chk("wr_cpu_load", cpu_rdata, 32'h12345678);

        // ---- reset held 2 cycles during EXT of a write ----
        ext_req = 1'b1; ext_addr = 32'h24; ext_wdata = 32'h00000BAD; ext_we = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rstx_we0", 32'(mem_we), 0);
        step();
        chk("rstx_we1", 32'(mem_we), 0);
        chk("rstx_ack1", 32'(ext_ack), 0);
        reset = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        step();
        chk("rstx_ack2", 32'(ext_ack), 0);
        chk("rstx_stall", 32'(cpu_stall), 0);
        chk("rstx_no_write", mem[8'h24], 0);

        // ---- burst: ext_req held for 10 transfers, MAX_BURST=4 ----
        ext_req = 1'b1; ext_addr = 32'h10; ext_we = 1'b0;
        acks = 0; burst = 0; done_before = 0; nbursts = 0; gnts = 0; cpu_free = 0; last_ack = -10;
        for (cyc = 0; cyc < 60 && nbursts < 3; cyc++) begin
            step();
            if (ext_gnt) gnts++;
            if (ext_ack) begin
                acks++;
                burst++;
                chk("bst_rdata", ext_rdata, 32'hDEADBEEF);
                if (burst > 1) chk("bst_spacing", 32'(cyc - last_ack), 2);
                last_ack = cyc;
                if (acks == 10) ext_req = 1'b0;
            end
            if (!cpu_stall) begin
                cpu_free++;
                if (burst != 0) begin
                    exp_b = (10 - done_before >= 4) ? 4 : 10 - done_before;
                    chk("bst_size", 32'(burst), 32'(exp_b));
                    done_before += burst;
                    burst = 0;
                    nbursts++;
                end
            end
        end
        chk("bst_total", 32'(acks), 10);
        chk("bst_gnts", 32'(gnts), 3);
        chk("bst_cpu_cycles", 32'(cpu_free), 3);
        ext_req = 1'b0;

        // ---- CPU store in the cycle ext_req rises ----
        cpu_we = 1'b1; cpu_addr = 32'h04; cpu_wdata = 32'hCAFE0004;
        ext_req = 1'b1; ext_addr = 32'h40; ext_we = 1'b0;
        shadow[8'h04] = 32'hCAFE0004;
        #1;
        chk("st_we", 32'(mem_we), 1);
        step();
        chk("st_gnt", 32'(ext_gnt), 1);
        chk("st_frozen_we", 32'(mem_we), 0);
        step();
        chk("st_ext_we", 32'(mem_we), 0);
        step();
        chk("st_ack", 32'(ext_ack), 1);
        ext_req = 1'b0;
        step();
        cpu_we = 1'b0;
        step();
        chk("st_mem", mem[8'h04], 32'hCAFE0004);

        // ---- external write into the I/O region ----
        ext_req = 1'b1; ext_addr = 32'h80; ext_wdata = 32'h00000055; ext_we = 1'b1;
        step();
        step();
`ifdef DMEM_ARB_IO_PROTECT_EN
        chk("io_we", 32'(mem_we), 0);
`else
        chk("io_we", 32'(mem_we), 1);
`endif
        step();
        chk("io_ack", 32'(ext_ack), 1);
`ifdef DMEM_ARB_IO_PROTECT_EN
        chk("io_err", 32'(ext_err), 1);
`else
        chk("io_err", 32'(ext_err), 0);
        shadow[8'h80] = 32'h00000055;
`endif
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        chk("io_err_clr", 32'(ext_err), 0);
        step();
        chk("io_mem", mem[8'h80], shadow[8'h80]);

        // ---- randomized transfers with random CPU stores ----
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 2 + int'($urandom_range(0, 2)); k++) begin
                cpu_random();
                step();
            end
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 8'($urandom_range(0, 127));
            r_data = $urandom;
            ext_req = 1'b1; ext_addr = {24'h0, r_addr}; ext_wdata = r_data; ext_we = r_we;
            cpu_random();
            lat = 0; gnt_lat = -1;
            while (lat < 10) begin
                step();
                lat++;
                if (ext_gnt) gnt_lat = lat;
                if (ext_ack) break;
                cpu_random();
            end
            chk("rnd_gnt_lat", 32'(gnt_lat), 1);
            chk("rnd_ack_lat", 32'(lat), 3);
            if (ext_ack) begin
                if (r_we) shadow[r_addr] = r_data;
                else chk("rnd_rdata", ext_rdata, shadow[r_addr]);
            end
            ext_req = 1'b0; ext_we = 1'b0;
            cpu_random();
            step();
        end
        cpu_we = 1'b0;
        step();
        step();
        for (int a = 0; a < 128; a++) begin
            if (mem[a] !== shadow[a]) chk("rnd_mem", mem[a], shadow[a]);
        end
        chk("rnd_mem_sample", mem[8'h20], shadow[8'h20]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_dmem_arbiter.md
Name: sc_dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the single-cycle CPU and one external master, such as a debug or loader engine.
- Sits between `sc_cpu` and `sc_datamem`, and drives the memory address, write-data and write-enable signals.
- When the external master is served, it asserts `cpu_stall`, which the top level uses to gate the CPU clock enable.
- Bounded bursts guarantee the CPU regains the port.

Parameters:
- ADDR_W, 32: width of the data-memory address.
- DATA_W, 32: width of the data words.
- MAX_BURST, 4: maximum number of consecutive external transfers before the port is returned to the CPU for at least 1 cycle. Legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU data address (the ALU result)
- cpu_wdata  in  DATA_W  CPU store data
- cpu_we  in  1  CPU store enable
- cpu_rdata  out  DATA_W  memory read data returned to the CPU; equal to mem_rdata
- cpu_stall  out  1  registered; 1 freezes the CPU (no pc update, no register-file write)
- ext_req  in  1  external request; level, held until ext_ack
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_we  in  1  external write enable
- ext_gnt  out  1  registered; 1-cycle pulse when the handover completes
- ext_ack  out  1  registered; 1-cycle pulse per completed transfer
- ext_rdata  out  DATA_W  registered; read data captured at ext_ack
- ext_err  out  1  registered; 1-cycle pulse on a blocked write (only with the optional feature)
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory; valid 1 cycle after the address is presented

Behaviour:
- Reset (synchronous, active-high):
  - state is set to CPU and burst_cnt to 0.
  - cpu_stall, ext_gnt, ext_ack and ext_err are 0; ext_rdata is 0.
  - While reset is high, mem_we is forced to 0 combinationally.
  - Reset mid-transfer aborts the transfer with no ack; an external write issued in the reset cycle is suppressed.
- States:
  - CPU:
    - Memory mux selects the cpu_* signals; cpu_stall=0.
    - If ext_req=1, go to HANDOVER; the CPU instruction in the current cycle completes normally.
  - HANDOVER:
    - cpu_stall=1, mem_we=0, and the mux selects ext_*.
    - ext_gnt pulses in this cycle. Go to EXT.
  - EXT:
    - mem_addr, mem_wdata and mem_we come from ext_*.
    - Go to DONE.
  - DONE:
    - mem_we=0; ext_ack=1 and ext_rdata<=mem_rdata; burst_cnt<=burst_cnt+1.
    - If ext_req=1 and burst_cnt+1<MAX_BURST, go to EXT.
    - Otherwise go to RELEASE.
  - RELEASE:
    - cpu_stall=0 at the next edge, burst_cnt<=0, mux selects cpu_*.
    - Go to CPU. The CPU always executes at least 1 cycle before the next HANDOVER.
- Latency:
  - First transfer: ext_req rising to ext_ack is 3 cycles (HANDOVER, EXT, DONE).
  - Back-to-back transfers within a burst: ext_ack every 2 cycles.
- Handshake rules:
  - The external master must hold ext_req and ext_addr/ext_wdata/ext_we stable until ext_ack.
  - If ext_req drops in HANDOVER or EXT, the current transfer still completes; an ack with no request is legal.
- Arithmetic: burst_cnt is 4 bits, unsigned, with no wrap; it saturates at MAX_BURST.
- Simultaneous events:
  - ext_req asserted during RELEASE is ignored until CPU state. This gives the CPU priority for exactly 1 cycle.
  - A CPU store in the cycle ext_req is sampled in CPU state is performed.
- While cpu_stall=1, cpu_we is ignored; the CPU is frozen.

Optional Feature:
- DMEM_ARB_IO_PROTECT_EN defined:
  - An external write with ext_addr[7]=1 (the I/O-mapped region, i.e. the output and input ports) is blocked.
  - In that EXT cycle mem_we is forced to 0.
  - In DONE, ext_err pulses together with ext_ack.
- Not defined: ext_err is tied to 0 and all external writes pass through.

Test Plan:
- Reset held 2 cycles during EXT with ext_we=1 -> mem_we=0 in both cycles, no ext_ack, cpu_stall=0 the cycle after reset drops.
- Single external read, ext_addr=0x10, memory word 0xDEADBEEF -> ext_gnt at cycle 1, ext_ack at cycle 3 with ext_rdata=0xDEADBEEF, cpu_stall high for cycles 1-4 and 0 from cycle 5.
- External write 0x12345678 to 0x20, followed by a CPU load from 0x20 -> CPU reads 0x12345678; mem_we high only in the EXT cycle.
- ext_req held high for 10 transfers, MAX_BURST=4:
  - Exactly 4 acks, then cpu_stall=0 for at least 1 cycle, then a new HANDOVER.
  - Total acks 10; the CPU pc advances between bursts.
- CPU store to 0x04 in the same cycle ext_req rises -> the store is performed, then handover proceeds.
- With DMEM_ARB_IO_PROTECT_EN, external write to 0x80 -> mem_we stays 0, ext_err and ext_ack pulse together. Without the macro -> write occurs and ext_err stays 0.
